tc_bus_arbiter_switch: RTL and testbench
========================================

# tc_bus_arbiter_switch

Multi-channel successor to the single tri-state switch: CHANNELS requesters compete for one shared BIT_WIDTH bus and a round-robin arbiter grants at most one per cycle. The winner's data is registered and driven onto `out`; with no grant the bus floats (Z). The block sits between component outputs and a shared bus net, replacing several parallel switches that would otherwise contend.

## Interface
- UUID, 0, component instance id (passthrough, no functional effect)
- NAME, "", component instance name (passthrough)
- BIT_WIDTH, 8, bus data width, ≥1
- CHANNELS, 4, number of requesting channels, 2..16
- MAX_BURST, 4, max consecutive cycles one channel may hold the bus while others request (lock mode only), ≥1

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  CHANNELS  per-channel request; bit i = channel i wants the bus
- in  input  CHANNELS*BIT_WIDTH  packed channel data; channel i at [i*BIT_WIDTH +: BIT_WIDTH]
- out  output  BIT_WIDTH  registered bus value of granted channel; all Z when `valid`=0
- grant  output  CHANNELS  one-hot registered grant, all 0 when idle
- valid  output  1  1 when `out` is driven this cycle

## Operation
- Registered state: `ptr` (index of last granted channel), `grant`, data register, `valid`, burst counter `burst` (lock mode only).
- Each edge: if no `en` bit set → `grant`=0, `valid`=0, data register holds its old value, `out`=Z. `ptr` unchanged.
- Otherwise select first set `en` bit scanning from (`ptr`+1) mod CHANNELS upward with wrap; set that `grant` bit, `valid`=1, data register = that channel's `in` slice, `ptr` = selected index.
- Exactly one `grant` bit high whenever `valid`=1; `grant`=0 whenever `valid`=0.
- `out` = data register when `valid`=1, else {BIT_WIDTH{1'bZ}}. No combinational path from `en`/`in` to `out`.
- Single requester repeatedly asserting `en` wins every cycle (scan wraps back to itself).

## Timing
- Latency: `en`/`in` sampled at edge N → `grant`, `valid`, `out` reflect them from edge N through edge N+1.
- Data captured once per grant cycle; `in` changes between edges have no effect.
- Reset (asserted any time, including mid-burst): immediately `grant`=0, `valid`=0, `out`=Z, data register=0, `ptr`=CHANNELS-1 (so channel 0 is highest priority on first arbitration), `burst`=0. First grant at first rising edge after `rst` deasserts.
- Requester dropping `en` loses the bus at the next edge; no partial-cycle drive.
- All `en` set every cycle → grants rotate 0,1,2,…,CHANNELS-1,0 (non-lock mode).

## Configuration
- Macro TC_BUS_ARBITER_SWITCH_LOCK_EN.
- Defined: burst lock. If the channel granted in the previous cycle still asserts `en`, it keeps the grant and `burst` increments (saturating at MAX_BURST). When `burst` reaches MAX_BURST and any other `en` bit is set, normal round-robin from `ptr`+1 applies and `burst` resets to 1 for the new winner. If no other requester, holder keeps the bus indefinitely. A channel switch or idle cycle resets `burst` (to 1 on new grant, 0 on idle).
- Not defined: no `burst` register; pure per-cycle round-robin as in Operation.

## Test plan
- Reset: `rst`=1 mid-transfer with `en`=4'b1111 → same cycle `out`=Z, `grant`=0, `valid`=0; after release, first edge grants channel 0.
- Rotation (no lock): CHANNELS=4, `en`=4'b1111, `in`={8'h44,8'h33,8'h22,8'h11} held 6 cycles → `out` 11,22,33,44,11,22; `grant` 0001,0010,0100,1000,0001,0010.
- Sparse/wrap: `ptr`=2 after granting ch2, `en`=4'b0011 → grant ch0 (wrap past 3), next cycle ch1.
- Idle: `en`=0 for 3 cycles after a grant → `out`=Z, `valid`=0, `grant`=0; then `en`=4'b0100 → ch2 granted, `out`=ch2 data next cycle.
- Lock (macro defined, MAX_BURST=4): `en`=4'b0011 constant → ch0 granted 4 cycles, ch1 4 cycles, ch0 4 cycles; with only `en`=4'b0001 → ch0 held 10+ cycles.
- Latency: change ch0 `in` from 8'hA5 to 8'h5A between edges → `out` updates only after next edge, never mid-cycle.

Source files
------------

// File: rtl/tc_bus_arbiter_switch.sv
// Purpose: round-robin arbiter driving one winner's registered data onto a shared tri-state bus.
// Latency: en/in sampled at a rising edge appear on grant/valid/out right after that edge (1 cycle).
// Backpressure: none; losing requesters simply retry. Optional burst lock is enabled by TC_BUS_ARBITER_SWITCH_LOCK_EN.
module tc_bus_arbiter_switch #(
    parameter int    UUID      = 0,
    parameter string NAME      = "",
    parameter int    BIT_WIDTH = 8,
    parameter int    CHANNELS  = 4,
    parameter int    MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           en,
    input  logic [CHANNELS*BIT_WIDTH-1:0] in,
    output logic [BIT_WIDTH-1:0]          out,
    output logic [CHANNELS-1:0]           grant,
    output logic                          valid
);

    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        ptr_d;
    logic [CHANNELS-1:0]  grant_d;
    logic                 valid_d;
    logic [BIT_WIDTH-1:0] data_q;
    logic [BIT_WIDTH-1:0] data_d;

    logic                 rr_found;
    logic [PW-1:0]        rr_idx;

`ifdef TC_BUS_ARBITER_SWITCH_LOCK_EN
    localparam int            BW   = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

    logic [BW-1:0] burst_q;
    logic [BW-1:0] burst_d;
    logic          holder_req;
    logic          others_req;
    logic          hold;
`endif

    // Round-robin scan: first requester after the last winner, wrapping back to it last.
    always_comb begin
        int           pos;
        logic [PW-1:0] idx;
        pos      = 0;
        idx      = '0;
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        for (int k = 1; k <= CHANNELS; k++) begin
            pos = (int'(ptr_q) + k) % CHANNELS;
            idx = PW'(pos);
            if (!rr_found && en[idx]) begin
                rr_found = 1'b1;
                rr_idx   = idx;
            end
        end
    end

`ifdef TC_BUS_ARBITER_SWITCH_LOCK_EN
    // The previous winner keeps the bus until its burst is used up, unless it is alone.
    always_comb begin
        holder_req = valid && |(en & grant);
        others_req = |(en & ~grant);
        hold       = holder_req && ((burst_q < MAXB) || !others_req);
    end
`endif

    // Next-state: pick a winner (or go idle) and capture its data slice.
    always_comb begin
        logic          take;
        logic [PW-1:0] sel;
        ptr_d   = ptr_q;
        grant_d = '0;
        valid_d = 1'b0;
        data_d  = data_q;
        take    = rr_found;
        sel     = rr_idx;
`ifdef TC_BUS_ARBITER_SWITCH_LOCK_EN
        burst_d = '0;
        if (hold) begin
            take    = 1'b1;
            sel     = ptr_q;
            burst_d = (burst_q < MAXB) ? burst_q + 1'b1 : burst_q;
        end else if (rr_found) begin
            burst_d = BW'(1);
        end
`endif
        if (take) begin
            grant_d = CHANNELS'(1) << sel;
            valid_d = 1'b1;
            data_d  = in[sel*BIT_WIDTH +: BIT_WIDTH];
            ptr_d   = sel;
        end
    end

    // State registers; reset makes channel 0 the first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= PW'(CHANNELS - 1);
            grant   <= '0;
            valid   <= 1'b0;
            data_q  <= '0;
`ifdef TC_BUS_ARBITER_SWITCH_LOCK_EN
            burst_q <= '0;
`endif
        end else begin
            ptr_q   <= ptr_d;
            grant   <= grant_d;
            valid   <= valid_d;
            data_q  <= data_d;
`ifdef TC_BUS_ARBITER_SWITCH_LOCK_EN
            burst_q <= burst_d;
`endif
        end
    end

    // Bus drive: only the registered value, floated whenever nobody holds the grant.
    assign out = valid ? data_q : {BIT_WIDTH{1'bz}};

endmodule

// File: tb/tb_tc_bus_arbiter_switch.sv
// Purpose: self-checking bench for tc_bus_arbiter_switch (default and burst-lock builds).
// Latency: checks land 2 ns after each rising edge; stimulus changes 3 ns after each edge.
// Backpressure: not applicable; all waits are fixed cycle counts.
module tb_tc_bus_arbiter_switch;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [C-1:0]   en  = '0;
    logic [C*W-1:0] din = '0;
    wire  [W-1:0]   dout;
    logic [C-1:0]   grant;
    logic           valid;

    logic [W-1:0]   zb = 'z;

    int errors = 0;
    int checks = 0;

    tc_bus_arbiter_switch #(
        .UUID(0), .NAME("arb0"), .BIT_WIDTH(W), .CHANNELS(C), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in(din),
        .out(dout), .grant(grant), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who should own the bus after each edge.
    bit           m_valid;
    logic [C-1:0] m_grant;
    logic [W-1:0] m_data;
    int           m_ptr;
    int           m_burst;
    bit           chk_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        int win;
        if (rst) begin
            m_valid = 0; m_grant = '0; m_data = '0; m_ptr = C - 1; m_burst = 0;
        end else begin
            win = -1;
`ifdef TC_BUS_ARBITER_SWITCH_LOCK_EN
            if (m_valid && en[m_ptr] && (m_burst < MB || (en & ~m_grant) == 0)) begin
                win = m_ptr;
                if (m_burst < MB) m_burst = m_burst + 1;
            end
`endif
            if (win < 0) begin
                for (int k = 1; k <= C; k++) begin
                    if (win < 0 && en[(m_ptr + k) % C]) win = (m_ptr + k) % C;
                end
                m_burst = 1;
            end
            if (win < 0) begin
                m_valid = 0; m_grant = '0; m_burst = 0;
            end else begin
                m_valid = 1;
                m_grant = '0;
                m_grant[win] = 1'b1;
                m_data = din[win*W +: W];
                m_ptr = win;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("cyc_valid", 32'(valid), 32'(m_valid));
            check("cyc_grant", 32'(grant), 32'(m_grant));
            check("cyc_out", dout, m_valid ? m_data : zb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_out", dout, zb);
        rst = 1'b0;

        // Rotation with all channels requesting.
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        en  = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
`ifdef TC_BUS_ARBITER_SWITCH_LOCK_EN
            check("lock_rot_grant", 32'(grant), (i < 4) ? 32'h1 : 32'h2);
`else
            check("rot_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
            check("rot_out", dout, 8'h11 * ((i % 4) + 1));
`endif
        end

        // Sparse request with wrap past channel 3.
        en = 4'b0100;
        tick();
        check("sparse_ch2", 32'(grant), 32'h4);
        en = 4'b0011;
        tick();
        check("wrap_ch0", 32'(grant), 32'h1);
        tick();
`ifdef TC_BUS_ARBITER_SWITCH_LOCK_EN
        check("lock_keep_ch0", 32'(grant), 32'h1);
`else
        check("wrap_ch1", 32'(grant), 32'h2);
`endif

        // Idle then a lone request from channel 2.
        en = 4'b0000;
        repeat (3) begin
            tick();
            check("idle_valid", 32'(valid), 32'd0);
            check("idle_grant", 32'(grant), 32'd0);
            check("idle_out", dout, zb);
        end
        en = 4'b0100;
        tick();
        check("idle_exit_grant", 32'(grant), 32'h4);
        check("idle_exit_out", dout, 8'h33);

        // Data is captured only at the edge.
        en = 4'b0001;
        din[7:0] = 8'hA5;
        tick();
        check("lat_first", dout, 8'hA5);
        din[7:0] = 8'h5A;
        #3;
        check("lat_hold", dout, 8'hA5);
        tick();
        check("lat_update", dout, 8'h5A);

        // Single requester keeps winning.
        repeat (5) begin
            tick();
            check("single_grant", 32'(grant), 32'h1);
            check("single_valid", 32'(valid), 32'd1);
        end

        // Reset in the middle of a transfer.
        en = 4'b1111;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_out", dout, zb);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_grant", 32'(grant), 32'h1);
        check("post_rst_out", dout, 8'h5A);

        // Two contenders from a clean reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en  = 4'b0011;
`ifdef TC_BUS_ARBITER_SWITCH_LOCK_EN
        for (int i = 0; i < 12; i++) begin
            tick();
            check("lock_burst_grant", 32'(grant), ((i / 4) % 2 == 0) ? 32'h1 : 32'h2);
        end
        en = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("lock_alone_grant", 32'(grant), 32'h1);
        end
`else
        for (int i = 0; i < 6; i++) begin
            tick();
            check("pair_grant", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
`endif

        en = '0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
